// File: rtl/arya_loader_pkg.sv
// Shared opcodes, state encoding and timing constants for the arya memory loader.
package arya_loader_pkg;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_VERIFY = 2'd1;
  localparam logic [1:0] OP_RUN    = 2'd2;
  localparam logic [1:0] OP_HALT   = 2'd3;

  localparam int unsigned RST_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_V_ADDR = 3'd2,
    ST_V_DATA = 3'd3,
    ST_V_HOLD = 3'd4,
    ST_RST    = 3'd5
  } state_e;

endpackage

// File: rtl/arya_mem_loader.sv
// Host-side load/verify/run/halt controller driving the arya core memory and reset pins.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of every transferred word.
module arya_mem_loader
  import arya_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  setup_mem,
  output logic                  verify_mem,
  output logic                  core_en,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  err
`ifdef LOADER_CHECKSUM_EN
  , output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(RST_CYCLES) + 1;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [LEN_W-1:0]      r_rem, w_rem_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_wr_ready, w_wr_ready_nxt;
  logic                  r_rd_valid, w_rd_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_data, w_mem_data_nxt;
  logic                  r_setup, w_setup_nxt;
  logic                  r_verify, w_verify_nxt;
  logic                  r_core_en, w_core_en_nxt;
  logic                  r_core_rst, w_core_rst_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_err, w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum, w_checksum_nxt;
`endif

  logic w_cmd_go, w_wr_go, w_rd_go;
  assign w_cmd_go = cmd_valid && r_cmd_ready;
  assign w_wr_go  = wr_valid && r_wr_ready;
  assign w_rd_go  = r_rd_valid && rd_ready;

  // Next-state and next-output logic; everything holds unless a case below changes it.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_addr_nxt = r_cur_addr;
    w_rem_nxt      = r_rem;
    w_cnt_nxt      = r_cnt;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_data_nxt  = r_rd_data;
    w_rd_addr_nxt  = r_rd_addr;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_setup_nxt    = 1'b0;
    w_core_en_nxt  = r_core_en;
    w_core_rst_nxt = r_core_rst;
    w_err_nxt      = r_err;
`ifdef LOADER_CHECKSUM_EN
    w_checksum_nxt = r_checksum;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_cmd_go) begin
          w_err_nxt = 1'b0;
          case (cmd_op)
            OP_LOAD, OP_VERIFY: begin
              if (cmd_len == '0) begin
                w_err_nxt = 1'b1;
              end else begin
                w_cur_addr_nxt = cmd_addr;
                w_rem_nxt      = cmd_len;
                w_core_en_nxt  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                w_checksum_nxt = '0;
`endif
                if (cmd_op == OP_LOAD) begin
                  w_state_nxt = ST_LOAD;
                end else begin
                  w_state_nxt    = ST_V_ADDR;
                  w_mem_addr_nxt = cmd_addr;
                end
              end
            end
            OP_RUN: begin
              w_state_nxt    = ST_RST;
              w_cnt_nxt      = CNT_W'(RST_CYCLES - 1);
              w_core_rst_nxt = 1'b1;
              w_core_en_nxt  = 1'b0;
            end
            OP_HALT: w_core_en_nxt = 1'b0;
          endcase
        end
      end
      ST_LOAD: begin
        if (w_wr_go) begin
          w_mem_addr_nxt = r_cur_addr;
          w_mem_data_nxt = wr_data;
          w_setup_nxt    = 1'b1;
          w_cur_addr_nxt = ADDR_WIDTH'(r_cur_addr + 1'b1);
          w_rem_nxt      = LEN_W'(r_rem - 1'b1);
`ifdef LOADER_CHECKSUM_EN
          w_checksum_nxt = r_checksum ^ wr_data;
`endif
          if (r_rem == LEN_W'(1)) w_state_nxt = ST_IDLE;
        end
      end
      ST_V_ADDR: w_state_nxt = ST_V_DATA;
      ST_V_DATA: begin
        // mem_rdata now answers the address presented during V_ADDR.
        w_rd_data_nxt  = mem_rdata;
        w_rd_addr_nxt  = r_cur_addr;
        w_rd_valid_nxt = 1'b1;
        w_state_nxt    = ST_V_HOLD;
      end
      ST_V_HOLD: begin
        if (w_rd_go) begin
          w_rd_valid_nxt = 1'b0;
          w_cur_addr_nxt = ADDR_WIDTH'(r_cur_addr + 1'b1);
          w_rem_nxt      = LEN_W'(r_rem - 1'b1);
`ifdef LOADER_CHECKSUM_EN
          w_checksum_nxt = r_checksum ^ r_rd_data;
`endif
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt    = ST_V_ADDR;
            w_mem_addr_nxt = ADDR_WIDTH'(r_cur_addr + 1'b1);
          end
        end
      end
      ST_RST: begin
        if (r_cnt == '0) begin
          w_state_nxt    = ST_IDLE;
          w_core_rst_nxt = 1'b0;
          w_core_en_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt - 1'b1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_verify_nxt    = (w_state_nxt == ST_V_ADDR) || (w_state_nxt == ST_V_DATA);
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_wr_ready_nxt  = (w_state_nxt == ST_LOAD);
  end

  // State and registered outputs; reset abandons any transfer with all strobes low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_addr   <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_setup     <= 1'b0;
      r_verify    <= 1'b0;
      r_core_en   <= 1'b0;
      r_core_rst  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_checksum  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_rem       <= w_rem_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_wr_ready  <= w_wr_ready_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_data  <= w_mem_data_nxt;
      r_setup     <= w_setup_nxt;
      r_verify    <= w_verify_nxt;
      r_core_en   <= w_core_en_nxt;
      r_core_rst  <= w_core_rst_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_checksum  <= w_checksum_nxt;
`endif
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign wr_ready     = r_wr_ready;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign rd_addr      = r_rd_addr;
  assign mem_addr_out = r_mem_addr;
  assign mem_data_out = r_mem_data;
  assign setup_mem    = r_setup;
  assign verify_mem   = r_verify;
  assign core_en      = r_core_en;
  assign core_rst     = r_core_rst;
  assign busy         = r_busy;
  assign err          = r_err;
`ifdef LOADER_CHECKSUM_EN
  assign checksum     = r_checksum;
`endif

endmodule
